// File: rtl/calc_digit_buffer_pkg.sv
// Shared types and constants for the calculator digit display path.
// Status codes, command positions and 7-segment glyphs used by the decoder and overlay.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BUSY  = 2'b01,
      ERROR = 2'b10,
      RSVD  = 2'b11
   } status_t;

   localparam logic [3:0] POS_CLEAR = 4'hF;
   localparam logic [3:0] DIG_MINUS = 4'hA;

   // Segment bytes are {dp,g,f,e,d,c,b,a}, 1 = lit.
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_R     = 8'h50;
   localparam logic [7:0] SEG_O     = 8'h5C;
   localparam logic [7:0] SEG_MINUS = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/calc_digit_buffer_if.sv
// Core-to-display bundle: write stream from the calculator core and the eight segment bytes.
// The core drives data/pos/status; the display stage drives d0..d7 (d0 is the rightmost digit).
interface calc_digit_buffer_if;

   logic [3:0] data;
   logic [3:0] pos;
   logic [1:0] status;
   logic [7:0] d0;
   logic [7:0] d1;
   logic [7:0] d2;
   logic [7:0] d3;
   logic [7:0] d4;
   logic [7:0] d5;
   logic [7:0] d6;
   logic [7:0] d7;

   modport master (
      output data, pos, status,
      input  d0, d1, d2, d3, d4, d5, d6, d7
   );

   modport slave (
      input  data, pos, status,
      output d0, d1, d2, d3, d4, d5, d6, d7
   );

endinterface

// File: rtl/calc_digit_buffer_seg7_decode.sv
// Combinational {valid, nibble} to 7-segment byte decoder; invalid entries are blank.
module seg7_decode
   import calc_pkg::*;
(
   input  logic       valid_i,
   input  logic [3:0] nib_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (valid_i) begin
         case (nib_i)
            4'd0:      seg_o = 8'h3F;
            4'd1:      seg_o = 8'h06;
            4'd2:      seg_o = 8'h5B;
            4'd3:      seg_o = 8'h4F;
            4'd4:      seg_o = 8'h66;
            4'd5:      seg_o = 8'h6D;
            4'd6:      seg_o = 8'h7D;
            4'd7:      seg_o = 8'h07;
            4'd8:      seg_o = 8'h7F;
            4'd9:      seg_o = 8'h6F;
            DIG_MINUS: seg_o = SEG_MINUS;
            default:   seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/calc_digit_buffer.sv
// Display stage: 8-entry digit buffer written by the core stream, with busy/error blink overlay
// and registered segment outputs.
module calc_digit_buffer
   import calc_pkg::*;
#(
   parameter int BLINK_DIV = 25_000_000
)(
   input  logic                 clock,
   input  logic                 reset,
   calc_digit_buffer_if.slave   bus
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

   status_t             status_in;
   status_t             status_q;
   logic                err_in;
   logic                err_entry;
   logic                wr_en;
   logic [7:0]          valid_q, valid_d;
   logic [3:0]          nib_q [8];
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                phase_q, phase_d;
   logic [7:0][7:0]     seg;
   logic [7:0][7:0]     d_q, d_d;

   assign status_in = status_t'(bus.status);
   assign err_in    = (status_in == ERROR);
   // Entering ERROR wipes the image; a write landing on the same edge is dropped.
   assign err_entry = err_in && (status_q != ERROR);
   assign wr_en     = !err_in && !bus.pos[3];

   always_comb begin
      valid_d = valid_q;
      if (err_entry) begin
         valid_d = '0;
      end else if (!err_in) begin
         if (!bus.pos[3]) begin
            valid_d[bus.pos[2:0]] = 1'b1;
         end else if (bus.pos == POS_CLEAR) begin
            valid_d = '0;
         end
      end
   end

   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      phase_d = phase_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         phase_d = !phase_q;
      end
   end

   // Nibble contents need no reset: an entry is only displayed once its valid bit is set.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         nib_q[bus.pos[2:0]] <= bus.data;
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_dec
      seg7_decode u_dec (
         .valid_i (valid_q[g]),
         .nib_i   (nib_q[g]),
         .seg_o   (seg[g])
      );
   end

   always_comb begin
      d_d = seg;
      case (status_q)
         BUSY: d_d[0][7] = phase_q;
         ERROR: begin
            d_d = '0;
            if (phase_q) begin
               d_d[4] = SEG_E;
               d_d[3] = SEG_R;
               d_d[2] = SEG_R;
               d_d[1] = SEG_O;
               d_d[0] = SEG_R;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q  <= '0;
         status_q <= IDLE;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
         d_q      <= '0;
      end else begin
         valid_q  <= valid_d;
         status_q <= status_in;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         d_q      <= d_d;
      end
   end

   assign bus.d0 = d_q[0];
   assign bus.d1 = d_q[1];
   assign bus.d2 = d_q[2];
   assign bus.d3 = d_q[3];
   assign bus.d4 = d_q[4];
   assign bus.d5 = d_q[5];
   assign bus.d6 = d_q[6];
   assign bus.d7 = d_q[7];

endmodule

// File: tb/tb_calc_digit_buffer.sv
// Directed bench for calc_digit_buffer with a cycle-level reference model feeding a scoreboard queue.
module tb_calc_digit_buffer;

   localparam int DIV = 4;
   localparam logic [63:0] ERR_IMG = 64'h00000079_50505C50;
   localparam logic [7:0] SEG_TBL [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   logic clock;
   logic reset;
   calc_digit_buffer_if bus ();

   calc_digit_buffer #(.BLINK_DIV(DIV)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int seen_err = 0;
   logic [63:0] sb_q [$];

   // Reference model state
   logic       m_valid [8];
   logic [3:0] m_nib [8];
   logic [1:0] m_stat;
   int         m_cnt;
   logic       m_phase;

   function automatic logic [63:0] obs_img();
      return {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
   endfunction

   function automatic logic [63:0] model_img();
      logic [63:0] img = '0;
      for (int i = 0; i < 8; i++)
         if (m_valid[i]) img[i*8 +: 8] = SEG_TBL[m_nib[i]];
      if (m_stat == 2'd2) img = m_phase ? ERR_IMG : 64'h0;
      else if (m_stat == 2'd1) img[7] = m_phase;
      return img;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_stat = 2'd0;
      m_cnt = 0;
      m_phase = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] p, input logic [3:0] dt, input logic [1:0] st);
      bit err = (st == 2'd2);
      sb_q.push_back(model_img());
      if (err && m_stat != 2'd2) begin
         for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      end else if (!err) begin
         if (p < 4'd8) begin
            m_nib[p] = dt;
            m_valid[p] = 1'b1;
         end else if (p == 4'hF) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         end
      end
      m_stat = st;
      if (m_cnt == DIV - 1) begin
         m_cnt = 0;
         m_phase = !m_phase;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [3:0] p, input logic [3:0] dt, input logic [1:0] st);
      logic [63:0] exp;
      bus.pos = p;
      bus.data = dt;
      bus.status = st;
      model_step(p, dt, st);
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: scoreboard empty, observed %h expected an entry", tag, obs_img());
      end else begin
         exp = sb_q.pop_front();
         check(tag, obs_img(), exp);
         if (obs_img() == ERR_IMG) seen_err++;
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.pos = 4'h8;
      bus.data = 4'h0;
      bus.status = 2'd0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("reset_image", obs_img(), 64'h0);
      reset = 1'b1;

      cyc("idle0", 4'h8, 4'h0, 2'd0);
      cyc("idle1", 4'h8, 4'h0, 2'd0);
      check("idle_blank", obs_img(), 64'h0);

      cyc("wr0_7", 4'h0, 4'h7, 2'd0);
      cyc("wr0_7_lat", 4'h8, 4'h0, 2'd0);
      check("d0_is_7", obs_img(), 64'h07);

      cyc("wr2_A", 4'h2, 4'hA, 2'd0);
      cyc("wr1_3", 4'h1, 4'h3, 2'd0);
      cyc("wr0_9", 4'h0, 4'h9, 2'd0);
      cyc("wr_lat", 4'h8, 4'h0, 2'd0);
      check("minus_3_9", obs_img(), 64'h00000000_00404F6F);
      cyc("clear", 4'hF, 4'h0, 2'd0);
      cyc("clear_lat", 4'h8, 4'h0, 2'd0);
      check("cleared", obs_img(), 64'h0);

      cyc("pos9_noop", 4'h9, 4'h5, 2'd0);
      cyc("pos9_lat", 4'h8, 4'h0, 2'd0);
      check("pos9_blank", obs_img(), 64'h0);
      cyc("wr7_C", 4'h7, 4'hC, 2'd0);
      cyc("wr7_lat", 4'h8, 4'h0, 2'd0);
      check("d7_blank_glyph", obs_img(), 64'h0);

      cyc("b2b_a", 4'h3, 4'h1, 2'd0);
      cyc("b2b_b", 4'h3, 4'h8, 2'd0);
      cyc("b2b_lat", 4'h8, 4'h0, 2'd0);
      check("b2b_last_wins", obs_img(), 64'h00000000_7F000000);
      cyc("clr2", 4'hF, 4'h0, 2'd0);

      cyc("err_ld1", 4'h1, 4'h1, 2'd0);
      cyc("err_ld0", 4'h0, 4'h2, 2'd0);
      cyc("err_ld_lat", 4'h8, 4'h0, 2'd0);
      check("buf_1_2", obs_img(), 64'h00000000_0000065B);
      cyc("err_entry_wr", 4'h0, 4'h4, 2'd2);
      for (int i = 0; i < 12; i++) cyc("err_blink", 4'h0, 4'h5, 2'd2);
      vectors++;
      assert (seen_err > 0) else begin
         miscompares++;
         $error("FAIL err_glyph_seen: observed %0d expected >0", seen_err);
      end
      cyc("err_exit", 4'h8, 4'h0, 2'd0);
      cyc("err_exit_lat", 4'h8, 4'h0, 2'd0);
      check("after_err_blank", obs_img(), 64'h0);

      cyc("busy_ld", 4'h0, 4'h5, 2'd0);
      for (int i = 0; i < 10; i++) cyc("busy_blink", 4'h8, 4'h0, 2'd1);
      cyc("busy_exit", 4'h8, 4'h0, 2'd0);
      cyc("busy_exit_lat", 4'h8, 4'h0, 2'd0);
      check("busy_exit_d0", obs_img(), 64'h6D);

      for (int i = 0; i < 3; i++) cyc("rsvd_idle", 4'h8, 4'h0, 2'd3);

      for (int i = 0; i < 5; i++) cyc("pre_rst_busy", 4'h8, 4'h0, 2'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", obs_img(), 64'h0);
      model_reset();
      @(posedge clock);
      #1;
      check("reset_hold", obs_img(), 64'h0);
      reset = 1'b1;
      cyc("post_rst_wr", 4'h0, 4'h5, 2'd1);
      for (int i = 0; i < 10; i++) cyc("post_rst_blink", 4'h8, 4'h0, 2'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
